// File: rtl/axis_demux_2_pkg.sv
// Shared stream definitions for the two-way AXI-Stream demux.
// Port indices double as the per-beat destination tag.
package axis_demux_2_pkg;

    typedef enum logic {
        PORT_0 = 1'b0,
        PORT_1 = 1'b1
    } port_e;

    localparam int NUM_PORTS = 2;

endpackage

// File: rtl/axis_demux_out_stage.sv
// Output register plus skid register for the demux; every beat carries its destination tag.
// The skid register absorbs the single beat in flight when the addressed sink stalls.
module axis_demux_out_stage
    import axis_demux_2_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] int_tdata,
    input  logic                  int_tlast,
    input  logic                  int_tuser,
    input  port_e                 int_dest,
    input  logic                  int_valid,
    output logic                  tready_int_early,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_tdata,
    output logic                  out_tlast,
    output logic                  out_tuser,
    output port_e                 out_dest,
    output logic                  out_valid
);

    localparam int BW = DATA_WIDTH + 3;

    logic [BW-1:0] int_beat;
    logic [BW-1:0] out_beat_reg;
    logic [BW-1:0] temp_beat_reg;
    logic          out_valid_reg, out_valid_next;
    logic          temp_valid_reg, temp_valid_next;
    logic          tready_int_reg;
    logic          store_int_to_out, store_int_to_temp, store_temp_to_out;

    assign int_beat = {int_tdata, int_tlast, int_tuser, int_dest};

    // Safe to accept next cycle if the head drains now, or enough storage stays free.
    assign tready_int_early = out_ready
                            || (!temp_valid_reg && !out_valid_reg)
                            || (!temp_valid_reg && !int_valid);

    always_comb begin
        out_valid_next    = out_valid_reg;
        temp_valid_next   = temp_valid_reg;
        store_int_to_out  = 1'b0;
        store_int_to_temp = 1'b0;
        store_temp_to_out = 1'b0;
        if (tready_int_reg) begin
            if (out_ready || !out_valid_reg) begin
                out_valid_next   = int_valid;
                store_int_to_out = 1'b1;
            end else begin
                temp_valid_next   = int_valid;
                store_int_to_temp = 1'b1;
            end
        end else if (out_ready) begin
            out_valid_next    = temp_valid_reg;
            temp_valid_next   = 1'b0;
            store_temp_to_out = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_beat_reg   <= '0;
            temp_beat_reg  <= '0;
            out_valid_reg  <= 1'b0;
            temp_valid_reg <= 1'b0;
            tready_int_reg <= 1'b0;
        end else begin
            tready_int_reg <= tready_int_early;
            out_valid_reg  <= out_valid_next;
            temp_valid_reg <= temp_valid_next;
            if (store_int_to_out) begin
                out_beat_reg <= int_beat;
            end else if (store_temp_to_out) begin
                out_beat_reg <= temp_beat_reg;
            end
            if (store_int_to_temp) begin
                temp_beat_reg <= int_beat;
            end
        end
    end

    assign out_tdata = out_beat_reg[BW-1:3];
    assign out_tlast = out_beat_reg[2];
    assign out_tuser = out_beat_reg[1];
    assign out_dest  = port_e'(out_beat_reg[0]);
    assign out_valid = out_valid_reg;

endmodule

// File: rtl/axis_demux_2.sv
// Frame-aware 1-to-2 AXI-Stream demux: the destination is latched at frame start
// and held until the beat carrying tlast has been accepted.
module axis_demux_2
    import axis_demux_2_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] input_axis_tdata,
    input  logic                  input_axis_tvalid,
    output logic                  input_axis_tready,
    input  logic                  input_axis_tlast,
    input  logic                  input_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_0_axis_tdata,
    output logic                  output_0_axis_tvalid,
    input  logic                  output_0_axis_tready,
    output logic                  output_0_axis_tlast,
    output logic                  output_0_axis_tuser,
    output logic [DATA_WIDTH-1:0] output_1_axis_tdata,
    output logic                  output_1_axis_tvalid,
    input  logic                  output_1_axis_tready,
    output logic                  output_1_axis_tlast,
    output logic                  output_1_axis_tuser,
    input  logic                  enable,
    input  logic                  select
);

    logic                  frame_reg, frame_next;
    port_e                 select_reg, select_next;
    logic                  input_axis_tready_reg, input_axis_tready_next;
    logic                  int_valid;
    logic                  tready_int_early;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_tdata;
    logic                  out_tlast, out_tuser, out_valid;
    port_e                 out_dest;
    logic [NUM_PORTS-1:0]  port_tready, port_tvalid;

    // The registered tready is only high inside a frame, so it already implies frame_reg.
    assign int_valid = input_axis_tvalid && input_axis_tready_reg && frame_reg;

    always_comb begin
        frame_next  = frame_reg;
        select_next = select_reg;
        if (frame_reg) begin
            if (int_valid) begin
                frame_next = !input_axis_tlast;
            end
        end else if (enable && input_axis_tvalid) begin
            frame_next  = 1'b1;
            select_next = port_e'(select);
        end
        input_axis_tready_next = tready_int_early && frame_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_reg             <= 1'b0;
            select_reg            <= PORT_0;
            input_axis_tready_reg <= 1'b0;
        end else begin
            frame_reg             <= frame_next;
            select_reg            <= select_next;
            input_axis_tready_reg <= input_axis_tready_next;
        end
    end

    assign input_axis_tready = input_axis_tready_reg;

    axis_demux_out_stage #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_out_stage (
        .clk             (clk),
        .rst_n           (rst_n),
        .int_tdata       (input_axis_tdata),
        .int_tlast       (input_axis_tlast),
        .int_tuser       (input_axis_tuser),
        .int_dest        (select_reg),
        .int_valid       (int_valid),
        .tready_int_early(tready_int_early),
        .out_ready       (out_ready),
        .out_tdata       (out_tdata),
        .out_tlast       (out_tlast),
        .out_tuser       (out_tuser),
        .out_dest        (out_dest),
        .out_valid       (out_valid)
    );

    assign port_tready = {output_1_axis_tready, output_0_axis_tready};

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_tvalid[gi] = out_valid && (out_dest == port_e'(gi));
        end
    endgenerate

    // Only the addressed sink may stall the head beat.
    assign out_ready = port_tready[out_dest];

    assign output_0_axis_tdata  = out_tdata;
    assign output_0_axis_tlast  = out_tlast;
    assign output_0_axis_tuser  = out_tuser;
    assign output_0_axis_tvalid = port_tvalid[0];
    assign output_1_axis_tdata  = out_tdata;
    assign output_1_axis_tlast  = out_tlast;
    assign output_1_axis_tuser  = out_tuser;
    assign output_1_axis_tvalid = port_tvalid[1];

endmodule
